// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 16-bit WISC core. It presents the current
//   PC to instruction memory under a rd/rdy handshake. It loads the returned
//   instruction into the IF/ID register. A one-entry skid buffer absorbs a
//   response that arrives while decode is stalled. fetch_stall holds the PC
//   until an instruction has been accepted. A taken branch (flush_i) squashes
//   IF/ID and the skid, and lets the PC load its target.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_i              current PC
//   fetch_stall_o     1 = PC must hold (drives PC hlt)
//   imem_rd_o         instruction memory read request
//   imem_addr_o       read address (always pc_i)
//   imem_rdy_i        memory response valid this cycle
//   imem_data_i       instruction data, valid with imem_rdy_i
//   id_stall_i        decode cannot accept a new instruction
//   flush_i           taken branch / redirect this cycle
//   ifid_instr_o      IF/ID instruction (NOP_INSTR when invalid)
//   ifid_pc_plus1_o   IF/ID captured pc+1
//   ifid_valid_o      IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] pc_i,
   output logic              fetch_stall_o,
   output logic              imem_rd_o,
   output logic [DATA_W-1:0] imem_addr_o,
   input  logic              imem_rdy_i,
   input  logic [DATA_W-1:0] imem_data_i,
   input  logic              id_stall_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] ifid_instr_o,
   output logic [DATA_W-1:0] ifid_pc_plus1_o,
   output logic              ifid_valid_o
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] skid_instr_q;
   logic [DATA_W-1:0] skid_pc1_q;
   logic [DATA_W-1:0] ifid_instr_q;
   logic [DATA_W-1:0] ifid_pc1_q;
   logic              ifid_valid_q;
   logic [DATA_W-1:0] pc_plus1;

   // Natural-width add, so pc+1 wraps 16'hFFFF -> 16'h0000.
   assign pc_plus1    = pc_i + DATA_W'(1);
   assign imem_addr_o = pc_i;

   // The request drops in HOLD (the instruction is already in the skid) and
   // on a flush, because the PC is moving to the branch target. The reset
   // term keeps the request low and the PC held while rst_n is asserted.
   assign imem_rd_o     = rst_n && (state_q == FETCH) && !flush_i;
   assign fetch_stall_o = !rst_n ||
                          (!flush_i && ((state_q == HOLD) || !imem_rdy_i));

   // HOLD means the skid is full. FETCH means the skid is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         skid_instr_q <= NOP_INSTR;
         skid_pc1_q   <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc1_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else if (flush_i) begin
         // A flush beats id_stall. Any response in this cycle is dropped.
         state_q      <= FETCH;
         skid_instr_q <= NOP_INSTR;
         skid_pc1_q   <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_rdy_i) begin
                  if (!id_stall_i) begin
                     ifid_instr_q <= imem_data_i;
                     ifid_pc1_q   <= pc_plus1;
                     ifid_valid_q <= 1'b1;
                  end else begin
                     // The PC still advances. The captured word waits here.
                     skid_instr_q <= imem_data_i;
                     skid_pc1_q   <= pc_plus1;
                     state_q      <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!id_stall_i) begin
                  ifid_instr_q <= skid_instr_q;
                  ifid_pc1_q   <= skid_pc1_q;
                  ifid_valid_q <= 1'b1;
                  skid_instr_q <= NOP_INSTR;
                  skid_pc1_q   <= '0;
                  state_q      <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign ifid_instr_o    = ifid_instr_q;
   assign ifid_pc_plus1_o = ifid_pc1_q;
   assign ifid_valid_o    = ifid_valid_q;

endmodule
